ddr3_traffic_checker: RTL and testbench

Parametrised traffic generator and checker for the DDR3 memory controller user port. On start it writes NUM_WORDS patterned words from a base address, reads them back, and compares each returned word against a regenerated expectation. It adds a controller ready handshake, selectable data patterns, in-order read checking, error counting and a read timeout. Bring-up tops drive its pass/done outputs to LEDs and the ILA.

---
 rtl/ddr3_test_pkg.sv | 32 +++
 rtl/ddr3_pattern_gen.sv | 60 ++++++
 rtl/ddr3_traffic_checker.sv | 258 +++++++++++++++++++++++++
 tb/tb_ddr3_traffic_checker.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_test_pkg.sv
// Shared encodings for the DDR3 traffic checker: pattern modes, FSM states
// and maximal-length LFSR tap masks.
package ddr3_test_pkg;

  typedef enum logic [1:0] {
    PAT_INC  = 2'd0,
    PAT_WALK = 2'd1,
    PAT_LFSR = 2'd2,
    PAT_ADDR = 2'd3
  } pattern_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Tap masks for a right-shifting Fibonacci LFSR: feedback is the XOR of the
  // masked bits and enters at the MSB. Bit i set means term x^(width-i).
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      32'sd8:  taps = 32'h0000_001D;
      32'sd16: taps = 32'h0000_002D;
      32'sd32: taps = 32'hC000_0401;
      default: taps = 32'h0000_002D;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/ddr3_pattern_gen.sv
// Per-word data pattern source; one copy drives write data, another regenerates
// the expected read data. init restarts the sequence, advance steps one word.
module ddr3_pattern_gen
  import ddr3_test_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 18,
  parameter int          DQ_BITWIDTH = 16,
  parameter logic [31:0] LFSR_SEED   = 32'h0000_ACE1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   init,
  input  logic                   advance,
  input  logic [1:0]             mode,
  input  logic [ADDR_WIDTH-1:0]  address,
  output logic [DQ_BITWIDTH-1:0] data
);

  localparam logic [DQ_BITWIDTH-1:0] SEED = DQ_BITWIDTH'(LFSR_SEED);
  localparam logic [DQ_BITWIDTH-1:0] TAPS = DQ_BITWIDTH'(lfsr_taps(DQ_BITWIDTH));
  localparam logic [DQ_BITWIDTH-1:0] ONE  = DQ_BITWIDTH'(1'b1);

  logic [DQ_BITWIDTH-1:0] index;
  logic [DQ_BITWIDTH-1:0] walk;
  logic [DQ_BITWIDTH-1:0] lfsr;

  // Word index, rotating one-hot and LFSR state advance together
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      index <= '0;
      walk  <= ONE;
      lfsr  <= SEED;
    end else if (init) begin
      index <= '0;
      walk  <= ONE;
      lfsr  <= SEED;
    end else if (advance) begin
      index <= index + ONE;
      walk  <= {walk[DQ_BITWIDTH-2:0], walk[DQ_BITWIDTH-1]};
      lfsr  <= {^(lfsr & TAPS), lfsr[DQ_BITWIDTH-1:1]};
    end else begin
      index <= index;
      walk  <= walk;
      lfsr  <= lfsr;
    end
  end

  // Select the pattern for the current word
  always_comb begin
    data = '0;
    case (pattern_t'(mode))
      PAT_INC:  data = index;
      PAT_WALK: data = walk;
      PAT_LFSR: data = lfsr;
      PAT_ADDR: data = DQ_BITWIDTH'(address);
      default:  data = '0;
    endcase
  end

endmodule

// File: rtl/ddr3_traffic_checker.sv
// Writes NUM_WORDS patterned words from a base address, reads them back in order
// and checks each return, with error counting and an idle read timeout.
module ddr3_traffic_checker
  import ddr3_test_pkg::*;
#(
  parameter int          ADDRESS_BITWIDTH      = 15,
  parameter int          BANK_ADDRESS_BITWIDTH = 3,
  parameter int          DQ_BITWIDTH           = 16,
  parameter int          NUM_WORDS             = 256,
  parameter logic [31:0] LFSR_SEED             = 32'h0000_ACE1,
  parameter int          TIMEOUT_CYCLES        = 4096
) (
  input  logic                                              clk,
  input  logic                                              resetn,
  input  logic                                              start,
  input  logic [1:0]                                        mode,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] base_address,
  input  logic                                              ready,
  output logic                                              write_enable,
  output logic                                              read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                            i_user_data,
  input  logic [DQ_BITWIDTH-1:0]                            o_user_data,
  input  logic                                              o_user_data_valid,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              pass,
  output logic                                              timeout,
  output logic [15:0]                                       error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address
);

  localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST   = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1'b1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] ONE_T  = TW'(1'b1);
  localparam logic [AW-1:0] ONE_A  = AW'(1'b1);

  logic [1:0]    rst_pipe;
  logic          rst_int_n;
  state_t        state;
  state_t        next_state;
  logic [1:0]    mode_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] check_address;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] chk_count;
  logic [CW-1:0] outstanding;
  logic [TW-1:0] timer;
  logic [DQ_BITWIDTH-1:0] write_data;
  logic [DQ_BITWIDTH-1:0] check_data;

  logic start_ok;
  logic write_accept;
  logic read_accept;
  logic ret_valid;
  logic mismatch;
  logic last_write;
  logic last_return;
  logic idle_tick;
  logic expire;

  // Reset asserts asynchronously and releases on a clock edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_int_n = rst_pipe[1];

  assign start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign write_accept = write_enable && ready;
  assign read_accept  = read_enable && ready;
  assign ret_valid    = o_user_data_valid && (state == ST_READ);
  assign mismatch     = ret_valid && (o_user_data != check_data);
  assign last_write   = write_accept && (wr_count == LAST);
  assign last_return  = ret_valid && (chk_count == LAST);
  assign idle_tick    = (state == ST_READ) && !read_accept && !ret_valid
                        && (read_enable || (outstanding != '0));
  assign expire       = idle_tick && (timer == T_LAST);
  assign i_user_data  = write_enable ? write_data : '0;

  ddr3_pattern_gen #(
    .ADDR_WIDTH (AW),
    .DQ_BITWIDTH(DQ_BITWIDTH),
    .LFSR_SEED  (LFSR_SEED)
  ) u_write_gen (
    .clk    (clk),
    .resetn (rst_int_n),
    .init   (start_ok),
    .advance(write_accept),
    .mode   (mode_q),
    .address(i_user_data_address),
    .data   (write_data)
  );

  ddr3_pattern_gen #(
    .ADDR_WIDTH (AW),
    .DQ_BITWIDTH(DQ_BITWIDTH),
    .LFSR_SEED  (LFSR_SEED)
  ) u_check_gen (
    .clk    (clk),
    .resetn (rst_int_n),
    .init   (start_ok),
    .advance(ret_valid),
    .mode   (mode_q),
    .address(check_address),
    .data   (check_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; a valid return on the terminal timer cycle wins
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          next_state = ST_WRITE;
        end else begin
          next_state = state;
        end
      end
      ST_WRITE: begin
        if (last_write) begin
          next_state = ST_READ;
        end else begin
          next_state = ST_WRITE;
        end
      end
      ST_READ: begin
        if (last_return || expire) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_READ;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Command issue, return checking, timeout and result registers
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      mode_q              <= 2'b00;
      base_q              <= '0;
      check_address       <= '0;
      wr_count            <= '0;
      rd_count            <= '0;
      chk_count           <= '0;
      outstanding         <= '0;
      timer               <= '0;
      write_enable        <= 1'b0;
      read_enable         <= 1'b0;
      i_user_data_address <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      pass                <= 1'b0;
      timeout             <= 1'b0;
      error_count         <= 16'h0000;
      first_error_address <= '0;
    end else begin
      busy <= (next_state == ST_WRITE) || (next_state == ST_READ);
      if (start_ok) begin
        mode_q              <= mode;
        base_q              <= base_address;
        check_address       <= base_address;
        i_user_data_address <= base_address;
        wr_count            <= '0;
        rd_count            <= '0;
        chk_count           <= '0;
        outstanding         <= '0;
        timer               <= '0;
        write_enable        <= 1'b1;
        read_enable         <= 1'b0;
        done                <= 1'b0;
        pass                <= 1'b0;
        timeout             <= 1'b0;
        error_count         <= 16'h0000;
        first_error_address <= '0;
      end else begin
        case (state)
          ST_WRITE: begin
            if (write_accept) begin
              wr_count <= wr_count + ONE_C;
              if (last_write) begin
                write_enable        <= 1'b0;
                read_enable         <= 1'b1;
                i_user_data_address <= base_q;
              end else begin
                i_user_data_address <= i_user_data_address + ONE_A;
              end
            end
          end
          ST_READ: begin
            if (read_accept) begin
              rd_count            <= rd_count + ONE_C;
              i_user_data_address <= i_user_data_address + ONE_A;
              if (rd_count == LAST) begin
                read_enable <= 1'b0;
              end
            end
            case ({read_accept, ret_valid})
              2'b10:   outstanding <= outstanding + ONE_C;
              2'b01:   outstanding <= outstanding - ONE_C;
              default: outstanding <= outstanding;
            endcase
            if (read_accept || ret_valid) begin
              timer <= '0;
            end else if (idle_tick) begin
              timer <= timer + ONE_T;
            end
            if (ret_valid) begin
              chk_count     <= chk_count + ONE_C;
              check_address <= check_address + ONE_A;
            end
            if (mismatch) begin
              if (error_count != 16'hFFFF) begin
                error_count <= error_count + 16'h0001;
              end
              if (error_count == 16'h0000) begin
                first_error_address <= check_address;
              end
            end
            if (last_return) begin
              done        <= 1'b1;
              pass        <= (error_count == 16'h0000) && !mismatch;
              read_enable <= 1'b0;
            end else if (expire) begin
              done        <= 1'b1;
              timeout     <= 1'b1;
              pass        <= 1'b0;
              read_enable <= 1'b0;
            end
          end
          default: begin
            done <= done;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Scoreboard bench: an ideal memory with random ready and return latency, a
// behavioural pattern model, and a monitor that checks every command and result.
module tb_ddr3_traffic_checker;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int NW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] base_address = '0;
  logic          ready = 1'b0;
  logic          write_enable, read_enable;
  logic [AW-1:0] i_user_data_address;
  logic [DW-1:0] i_user_data;
  logic [DW-1:0] o_user_data = '0;
  logic          o_user_data_valid = 1'b0;
  logic          busy, done, pass, timeout;
  logic [15:0]   error_count;
  logic [AW-1:0] first_error_address;

  ddr3_traffic_checker #(
    .ADDRESS_BITWIDTH     (15),
    .BANK_ADDRESS_BITWIDTH(3),
    .DQ_BITWIDTH          (DW),
    .NUM_WORDS            (NW),
    .TIMEOUT_CYCLES       (TO)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .start              (start),
    .mode               (mode),
    .base_address       (base_address),
    .ready              (ready),
    .write_enable       (write_enable),
    .read_enable        (read_enable),
    .i_user_data_address(i_user_data_address),
    .i_user_data        (i_user_data),
    .o_user_data        (o_user_data),
    .o_user_data_valid  (o_user_data_valid),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .timeout            (timeout),
    .error_count        (error_count),
    .first_error_address(first_error_address)
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d; int due;} ret_t;

  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  ret_t          ret_q[$];
  logic [DW-1:0] mem[int];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int corrupt_addr = -1;
  int drop_after = 0;
  bit rand_ready = 1'b0;
  int returns_sent = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int exp_errors = 0;
  logic [AW-1:0] exp_first = '0;
  int last_event = 0;
  int last_due = 0;
  int low_streak = 0;
  bit prev_pending = 1'b0;
  bit prev_we = 1'b0;
  logic [AW-1:0] prev_a;
  logic [DW-1:0] prev_d;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lfsr_after(input int n);
    int v;
    int b;
    v = 'hACE1;
    for (int i = 0; i < n; i++) begin
      b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
      v = (v >> 1) | (b << 15);
    end
    return DW'(v);
  endfunction

  function automatic logic [DW-1:0] pattern(input int m, input int k, input logic [AW-1:0] a);
    case (m)
      0:       return DW'(k);
      1:       return DW'(1 << (k % DW));
      2:       return lfsr_after(k);
      default: return a[DW-1:0];
    endcase
  endfunction

  // Memory side: ready and in-order read returns, presented just after each edge
  always @(posedge clk) begin
    ret_t r;
    #1;
    cyc++;
    if (!rand_ready) ready = 1'b1;
    else if (low_streak >= 6) ready = 1'b1;
    else ready = 1'($urandom_range(0, 1));
    low_streak = ready ? 0 : low_streak + 1;
    o_user_data_valid = 1'b0;
    o_user_data = '0;
    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      r = ret_q.pop_front();
      if (drop_after == 0 || returns_sent < drop_after) begin
        o_user_data_valid = 1'b1;
        o_user_data = r.d;
        returns_sent++;
        if (int'(r.a) == corrupt_addr) begin
          exp_errors++;
          if (exp_errors == 1) exp_first = r.a;
        end
      end
    end
  end

  // Monitor: compares every accepted command against the scoreboard queues
  always @(negedge clk) begin
    wr_t w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int due;
    if (!resetn) begin
      prev_pending = 1'b0;
    end else begin
      if (busy) check("cmd_exclusive", write_enable & read_enable, 1'b0);
      if (prev_pending) begin
        check("hold_addr", i_user_data_address, prev_a);
        if (prev_we) check("hold_data", i_user_data, prev_d);
      end
      if (write_enable && ready) begin
        wr_seen++;
        if (exp_wr.size() == 0) check("write_count", wr_seen, NW);
        else begin
          w = exp_wr.pop_front();
          check("write_addr", i_user_data_address, w.a);
          check("write_data", i_user_data, w.d);
          mem[int'(i_user_data_address)] = i_user_data;
        end
      end
      if (read_enable && ready) begin
        rd_seen++;
        last_event = cyc;
        if (exp_rd.size() == 0) check("read_count", rd_seen, NW);
        else begin
          a = exp_rd.pop_front();
          check("read_addr", i_user_data_address, a);
        end
        a = i_user_data_address;
        d = mem.exists(int'(a)) ? mem[int'(a)] : '0;
        if (int'(a) == corrupt_addr) d = d ^ 16'h0001;
        due = cyc + $urandom_range(1, 4);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        ret_q.push_back('{a, d, due});
      end
      if (o_user_data_valid && busy) last_event = cyc;
      prev_pending = (write_enable || read_enable) && !ready;
      prev_we = write_enable;
      prev_a = i_user_data_address;
      prev_d = i_user_data;
    end
  end

  task automatic prepare(input int m, input logic [AW-1:0] b, input int corrupt, input int drop, input bit rr);
    logic [AW-1:0] a;
    exp_wr.delete();
    exp_rd.delete();
    ret_q.delete();
    corrupt_addr = corrupt;
    drop_after = drop;
    rand_ready = rr;
    returns_sent = 0;
    wr_seen = 0;
    rd_seen = 0;
    exp_errors = 0;
    exp_first = '0;
    last_due = 0;
    for (int k = 0; k < NW; k++) begin
      a = b + AW'(k);
      exp_wr.push_back('{a, pattern(m, k, a)});
      exp_rd.push_back(a);
    end
    @(posedge clk);
    #2;
    mode = 2'(m);
    base_address = b;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic run_pass(input int m, input logic [AW-1:0] b, input int corrupt, input int drop, input bit rr);
    int n;
    int done_cyc;
    bit exp_to;
    prepare(m, b, corrupt, drop, rr);
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    exp_to = (drop > 0) && (drop < NW);
    check("done", done, 1'b1);
    check("busy_after_done", busy, 1'b0);
    check("timeout", timeout, exp_to);
    check("pass", pass, (!exp_to && exp_errors == 0));
    check("error_count", error_count, exp_errors);
    check("first_error_address", first_error_address, exp_first);
    check("writes_done", wr_seen, NW);
    check("reads_done", rd_seen, NW);
    check("writes_left", exp_wr.size(), 0);
    check("reads_left", exp_rd.size(), 0);
    if (exp_to) check("timeout_latency", done_cyc - last_event, TO + 1);
    repeat (3) @(negedge clk);
    check("done_held", done, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, write_enable, 1'b0);
    check({tag, "_re"}, read_enable, 1'b0);
    check({tag, "_addr"}, i_user_data_address, '0);
    check({tag, "_data"}, i_user_data, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_timeout"}, timeout, 1'b0);
    check({tag, "_errors"}, error_count, 16'h0000);
    check({tag, "_first_err"}, first_error_address, '0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("post_reset");

    run_pass(0, '0, -1, 0, 1'b0);
    run_pass(0, AW'(40), -1, 0, 1'b1);
    run_pass(1, '0, 5, 0, 1'b1);
    run_pass(int'($urandom_range(0, 3)), AW'((1 << AW) - 3), -1, 0, 1'b1);
    run_pass(0, AW'(100), -1, 6, 1'b1);

    prepare(0, AW'(200), -1, 0, 1'b1);
    n = 0;
    while (!read_enable && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_read", read_enable, 1'b1);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check_all_zero("mid_read_reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    ret_q.delete();
    repeat (4) @(negedge clk);
    run_pass(2, AW'($urandom_range(0, (1 << AW) - 1)), -1, 0, 1'b1);

    for (int p = 0; p < 4; p++) begin
      logic [AW-1:0] b;
      int c;
      b = AW'($urandom_range(0, (1 << AW) - 1));
      c = (p % 2 == 1) ? int'(b + AW'($urandom_range(0, NW - 1))) : -1;
      run_pass(int'($urandom_range(0, 3)), b, c, 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
